// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the two-port 8080-style LCD write bus arbiter.
package lcd_bus_pkg;

    localparam int DATA_W  = 16;
    localparam int NUM_REQ = 2;

    // Idle levels of the active-low bus strobes
    localparam logic CS_IDLE = 1'b1;
    localparam logic WR_IDLE = 1'b1;
    localparam logic RD_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WR_LO,
        ST_WR_HI,
        ST_CS_GAP
    } lcd_state_t;

    // One requester word as seen at the arbiter inputs
    typedef struct packed {
        logic              rs;
        logic              lock;
        logic [DATA_W-1:0] data;
    } lcd_word_t;

    // Pick the word of the port flagged in a one-hot select
    function automatic lcd_word_t sel_word(input logic [NUM_REQ-1:0] sel,
                                           input lcd_word_t w0,
                                           input lcd_word_t w1);
        return sel[1] ? w1 : w0;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-port winner select. On a tie the port that was not granted last wins;
// tying last_owner high makes port 0 the fixed tie winner.
module lcd_rr_arbiter
    import lcd_bus_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last_owner,
    output logic [NUM_REQ-1:0] winner
);

    // Single requester wins outright; a tie goes to the other port than last time
    always_comb begin
        winner = valid;
        if (&valid) begin
            winner = last_owner ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Arbitrates two word streams onto a write-only 8080-style LCD bus.
// Each word is SETUP -> WR_LO -> WR_HI; a locked owner chains words with cs
// held low, otherwise a one-cycle CS_GAP returns the bus to IDLE.
// Optional feature: define LCD_ARB_ROUND_ROBIN_EN for round-robin tie-break;
// without it port 0 always wins ties and no last-owner register exists.
module lcd_bus_arbiter
    import lcd_bus_pkg::*;
#(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int MAX_BURST   = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req0_valid,
    input  logic              req0_rs,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_lock,
    input  logic              req1_valid,
    input  logic              req1_rs,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_lock,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              lcd_cs,
    output logic              lcd_rs,
    output logic              lcd_wr,
    output logic              lcd_rd,
    output logic [DATA_W-1:0] data_output,
    output logic [1:0]        grant,
    output logic              busy
);

    lcd_state_t         state;
    logic [3:0]         phase_cnt;
    logic [7:0]         burst_cnt;
    logic               lock_q;
    logic               last_owner;

    logic [NUM_REQ-1:0] valid_v;
    logic [NUM_REQ-1:0] win;
    logic [NUM_REQ-1:0] take;
    lcd_word_t          word0;
    lcd_word_t          word1;
    lcd_word_t          word_in;
    logic               idle_accept;
    logic               phase_last_lo;
    logic               phase_last_hi;
    logic               owner_valid;
    logic               cont;

    assign valid_v = {req1_valid, req0_valid};
    assign word0   = '{rs: req0_rs, lock: req0_lock, data: req0_data};
    assign word1   = '{rs: req1_rs, lock: req1_lock, data: req1_data};

    lcd_rr_arbiter u_arb (
        .valid      (valid_v),
        .last_owner (last_owner),
        .winner     (win)
    );

    assign phase_last_lo = (phase_cnt == 4'(WR_LOW_CYC - 1));
    assign phase_last_hi = (phase_cnt == 4'(WR_HIGH_CYC - 1));
    assign owner_valid   = |(grant & valid_v);

    // Ready is withheld while reset is asserted so no word is lost to a reset edge
    assign idle_accept = (state == ST_IDLE) && (|valid_v) && n_rst;
    assign cont        = (state == ST_WR_HI) && phase_last_hi && lock_q && owner_valid
                         && (burst_cnt < 8'(MAX_BURST)) && n_rst;

    // Ready goes only to the IDLE winner or to the continuing owner
    assign take    = idle_accept ? win : (cont ? grant : '0);
    assign word_in = sel_word(take, word0, word1);

    assign req0_ready = take[0];
    assign req1_ready = take[1];
    assign lcd_rd     = RD_IDLE;

`ifdef LCD_ARB_ROUND_ROBIN_EN
    // Remember which port won the last IDLE grant for the next tie
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            last_owner <= 1'b1;
        end else if (idle_accept) begin
            last_owner <= win[1];
        end
    end
`else
    // Claiming port 1 as last owner makes port 0 the permanent tie winner
    assign last_owner = 1'b1;
`endif

    // Bus FSM; strobes, word and grant are registered alongside the state
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            lcd_cs      <= CS_IDLE;
            lcd_wr      <= WR_IDLE;
            lcd_rs      <= 1'b0;
            data_output <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            phase_cnt   <= '0;
            burst_cnt   <= '0;
            lock_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (idle_accept) begin
                        state       <= ST_SETUP;
                        lcd_cs      <= 1'b0;
                        lcd_wr      <= WR_IDLE;
                        grant       <= win;
                        busy        <= 1'b1;
                        burst_cnt   <= 8'd1;
                        lock_q      <= word_in.lock;
                        lcd_rs      <= word_in.rs;
                        data_output <= word_in.data;
                    end
                end
                ST_SETUP: begin
                    state     <= ST_WR_LO;
                    lcd_wr    <= 1'b0;
                    phase_cnt <= '0;
                end
                ST_WR_LO: begin
                    if (phase_last_lo) begin
                        state     <= ST_WR_HI;
                        lcd_wr    <= WR_IDLE;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end
                ST_WR_HI: begin
                    if (phase_last_hi) begin
                        if (cont) begin
                            // Chained word: cs stays low, new word latched at SETUP entry
                            state       <= ST_SETUP;
                            burst_cnt   <= burst_cnt + 8'd1;
                            lock_q      <= word_in.lock;
                            lcd_rs      <= word_in.rs;
                            data_output <= word_in.data;
                        end else begin
                            state  <= ST_CS_GAP;
                            lcd_cs <= CS_IDLE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end
                ST_CS_GAP: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    lcd_cs <= CS_IDLE;
                    lcd_wr <= WR_IDLE;
                    grant  <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: cycle tables for single words, a locked
// burst and tie-breaks, plus hand sequences for burst limit and mid-word reset.
module tb_lcd_bus_arbiter;

`ifdef LCD_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        req0_valid, req0_rs, req0_lock, req0_ready;
    logic        req1_valid, req1_rs, req1_lock, req1_ready;
    logic [15:0] req0_data, req1_data;
    logic        lcd_cs, lcd_rs, lcd_wr, lcd_rd;
    logic [15:0] data_output;
    logic [1:0]  grant;
    logic        busy;

    int total = 0;
    int bad   = 0;

    lcd_bus_arbiter #(.WR_LOW_CYC(2), .WR_HIGH_CYC(2), .MAX_BURST(4)) dut (
        .clk(clk), .n_rst(n_rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_lock(req0_lock),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_lock(req1_lock),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr), .lcd_rd(lcd_rd),
        .data_output(data_output), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  l;
        logic        rs;
        logic [15:0] d;
        logic [1:0]  e_r;
        logic        e_cs;
        logic        e_wr;
        logic [1:0]  e_g;
        logic        e_b;
        logic        e_rs;
        logic [15:0] e_d;
    } vec_t;

    vec_t        vecs[$];
    logic        cur_rs = 1'b0;
    logic [15:0] cur_d  = 16'h0000;

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] l, input logic rs,
                                input logic [15:0] d, input logic [1:0] e_r, input logic e_cs,
                                input logic e_wr, input logic [1:0] e_g, input logic e_b,
                                input logic e_rs, input logic [15:0] e_d);
        vec_t t;
        t.v = v; t.l = l; t.rs = rs; t.d = d; t.e_r = e_r; t.e_cs = e_cs; t.e_wr = e_wr;
        t.e_g = e_g; t.e_b = e_b; t.e_rs = e_rs; t.e_d = e_d;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Unlocked single word from IDLE: accept row, then SETUP, 2x WR_LO, 2x WR_HI, CS_GAP
    task automatic add_word(input logic [1:0] vin, input logic [1:0] win, input logic rs,
                            input logic [15:0] d, input bit pester);
        vecs.push_back(mk(vin, 2'b00, rs, d, win, H, H, 2'b00, L, cur_rs, cur_d));
        cur_rs = rs;
        cur_d  = d;
        for (int k = 1; k <= 6; k++) begin
            vecs.push_back(mk(pester ? 2'b11 : 2'b00, 2'b00, ~rs, ~d, 2'b00,
                              (k == 6), !(k == 2 || k == 3), win, H, cur_rs, cur_d));
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic rs, input logic [15:0] d);
        req0_valid = v[0]; req1_valid = v[1];
        req0_lock  = l[0]; req1_lock  = l[1];
        req0_rs    = rs;   req1_rs    = rs;
        req0_data  = d;    req1_data  = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0;
        logic [1:0] e_r;

        n_rst = 1'b0;
        drive(2'b00, 2'b00, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.cs", lcd_cs, 1);       chk("rst.wr", lcd_wr, 1);
        chk("rst.rd", lcd_rd, 1);       chk("rst.rs", lcd_rs, 0);
        chk("rst.data", data_output, 0); chk("rst.grant", grant, 0);
        chk("rst.busy", busy, 0);
        chk("rst.ready", {req1_ready, req0_ready}, 0);
        next_cycle();
        n_rst = 1'b1;

        // Single words on port 0; the first keeps both valids high while busy
        add_word(2'b01, 2'b01, 1'b0, 16'h0022, 1'b1);
        add_word(2'b01, 2'b01, 1'b1, 16'h1234, 1'b0);

        // Locked three-word burst on port 1; port 0 knocks at each continuation point
        vecs.push_back(mk(2'b10, 2'b10, H, 16'hF800, 2'b10, H, H, 2'b00, L, H, 16'h1234));
        vecs.push_back(mk(2'b10, 2'b10, H, 16'h07E0, 2'b00, L, H, 2'b10, H, H, 16'hF800));
        vecs.push_back(mk(2'b10, 2'b10, H, 16'h07E0, 2'b00, L, L, 2'b10, H, H, 16'hF800));
        vecs.push_back(mk(2'b10, 2'b10, H, 16'h07E0, 2'b00, L, L, 2'b10, H, H, 16'hF800));
        vecs.push_back(mk(2'b10, 2'b10, H, 16'h07E0, 2'b00, L, H, 2'b10, H, H, 16'hF800));
        vecs.push_back(mk(2'b11, 2'b10, H, 16'h07E0, 2'b10, L, H, 2'b10, H, H, 16'hF800));
        vecs.push_back(mk(2'b10, 2'b00, H, 16'h001F, 2'b00, L, H, 2'b10, H, H, 16'h07E0));
        vecs.push_back(mk(2'b10, 2'b00, H, 16'h001F, 2'b00, L, L, 2'b10, H, H, 16'h07E0));
        vecs.push_back(mk(2'b10, 2'b00, H, 16'h001F, 2'b00, L, L, 2'b10, H, H, 16'h07E0));
        vecs.push_back(mk(2'b10, 2'b00, H, 16'h001F, 2'b00, L, H, 2'b10, H, H, 16'h07E0));
        vecs.push_back(mk(2'b11, 2'b00, H, 16'h001F, 2'b10, L, H, 2'b10, H, H, 16'h07E0));
        vecs.push_back(mk(2'b00, 2'b00, H, 16'h0000, 2'b00, L, H, 2'b10, H, H, 16'h001F));
        vecs.push_back(mk(2'b00, 2'b00, H, 16'h0000, 2'b00, L, L, 2'b10, H, H, 16'h001F));
        vecs.push_back(mk(2'b00, 2'b00, H, 16'h0000, 2'b00, L, L, 2'b10, H, H, 16'h001F));
        vecs.push_back(mk(2'b00, 2'b00, H, 16'h0000, 2'b00, L, H, 2'b10, H, H, 16'h001F));
        vecs.push_back(mk(2'b00, 2'b00, H, 16'h0000, 2'b00, L, H, 2'b10, H, H, 16'h001F));
        vecs.push_back(mk(2'b00, 2'b00, H, 16'h0000, 2'b00, H, H, 2'b10, H, H, 16'h001F));
        vecs.push_back(mk(2'b00, 2'b00, H, 16'h0000, 2'b00, H, H, 2'b00, L, H, 16'h001F));
        cur_rs = 1'b1;
        cur_d  = 16'h001F;

        // Ties in IDLE; last owner is port 1 here
        add_word(2'b11, 2'b01, 1'b0, 16'hAAAA, 1'b0);
        add_word(2'b11, RR ? 2'b10 : 2'b01, 1'b1, 16'h5555, 1'b0);
        add_word(2'b11, 2'b01, 1'b0, 16'h0F0F, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].l, vecs[i].rs, vecs[i].d);
            @(negedge clk);
            chk($sformatf("vec%0d.ready", i), {req1_ready, req0_ready}, vecs[i].e_r);
            chk($sformatf("vec%0d.cs", i), lcd_cs, vecs[i].e_cs);
            chk($sformatf("vec%0d.wr", i), lcd_wr, vecs[i].e_wr);
            chk($sformatf("vec%0d.grant", i), grant, vecs[i].e_g);
            chk($sformatf("vec%0d.busy", i), busy, vecs[i].e_b);
            chk($sformatf("vec%0d.rs", i), lcd_rs, vecs[i].e_rs);
            chk($sformatf("vec%0d.data", i), data_output, vecs[i].e_d);
            chk($sformatf("vec%0d.rd", i), lcd_rd, 1);
            next_cycle();
        end

        // Burst limit: port 0 locked with words queued, port 1 waiting from t=1
        acc0 = 0;
        for (int t = 0; t <= 22; t++) begin
            req0_valid = 1'b1; req0_lock = 1'b1; req0_rs = 1'b0;
            req0_data  = 16'h0100 + 16'(acc0);
            req1_valid = (t >= 1); req1_lock = 1'b0; req1_rs = 1'b1; req1_data = 16'hC0DE;
            @(negedge clk);
            e_r[0] = (t == 0 || t == 5 || t == 10 || t == 15) || (t == 22 && !RR);
            e_r[1] = (t == 22 && RR);
            chk($sformatf("mb.t%0d.ready", t), {req1_ready, req0_ready}, e_r);
            if (t >= 16 && t <= 20) chk($sformatf("mb.t%0d.data", t), data_output, 16'h0103);
            if (t == 21) begin
                chk("mb.gap.cs", lcd_cs, 1);
                chk("mb.gap.busy", busy, 1);
            end
            if (t == 22) chk("mb.idle.grant", grant, 0);
            if (e_r[0]) acc0++;
            next_cycle();
        end
        drive(2'b00, 2'b00, 1'b0, 16'h0000);
        repeat (7) next_cycle();
        @(negedge clk);
        chk("mb.drain.busy", busy, 0);
        chk("mb.drain.cs", lcd_cs, 1);
        next_cycle();

        // Reset during WR_LO drops the word; next request starts clean
        drive(2'b10, 2'b00, 1'b1, 16'hBEEF);
        @(negedge clk);
        chk("rw.accept", {req1_ready, req0_ready}, 2'b10);
        next_cycle();
        drive(2'b00, 2'b00, 1'b0, 16'h0000);
        @(negedge clk);
        chk("rw.setup.cs", lcd_cs, 0);
        next_cycle();
        n_rst = 1'b0;
        @(negedge clk);
        chk("rw.wrlo.wr", lcd_wr, 0);
        chk("rw.wrlo.data", data_output, 16'hBEEF);
        next_cycle();
        @(negedge clk);
        chk("rw.rst.cs", lcd_cs, 1);     chk("rw.rst.wr", lcd_wr, 1);
        chk("rw.rst.rd", lcd_rd, 1);     chk("rw.rst.rs", lcd_rs, 0);
        chk("rw.rst.data", data_output, 0);
        chk("rw.rst.grant", grant, 0);   chk("rw.rst.busy", busy, 0);
        chk("rw.rst.ready", {req1_ready, req0_ready}, 0);
        next_cycle();
        n_rst = 1'b1;
        drive(2'b01, 2'b00, 1'b0, 16'h1357);
        @(negedge clk);
        chk("rw.re.accept", {req1_ready, req0_ready}, 2'b01);
        chk("rw.re.busy", busy, 0);
        next_cycle();
        drive(2'b00, 2'b00, 1'b0, 16'h0000);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("rw.k%0d.cs", k), lcd_cs, (k >= 6));
            chk($sformatf("rw.k%0d.wr", k), lcd_wr, !(k == 2 || k == 3));
            chk($sformatf("rw.k%0d.grant", k), grant, (k == 7) ? 2'b00 : 2'b01);
            chk($sformatf("rw.k%0d.data", k), data_output, 16'h1357);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 SHALL have parameter WR_LOW_CYC, default 2: cycles lcd_wr is held low per word (legal 1..15).
REQ-002 SHALL have parameter WR_HIGH_CYC, default 2: cycles lcd_wr is held high after each low phase (legal 1..15).
REQ-003 SHALL have parameter MAX_BURST, default 64: maximum words per locked grant (legal 1..255).
REQ-004 Ports (clock and reset first):
- clk  in  1  single system clock; all logic on rising edge.
- n_rst  in  1  synchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has a word.
- req0_rs / req1_rs  in  1  word type: 0 = command, 1 = data.
- req0_data / req1_data  in  16  word to write.
- req0_lock / req1_lock  in  1  keep the grant for the next word.
- req0_ready / req1_ready  out  1  word accepted this cycle.
- lcd_cs, lcd_rs, lcd_wr, lcd_rd  out  1  8080-style bus strobes; cs/wr/rd are active low.
- data_output  out  16  LCD data bus.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  high in every state except IDLE.

Function
REQ-005 SHALL transfer a word on reqN_valid && reqN_ready; reqN_valid SHALL NOT depend combinationally on reqN_ready.
REQ-006 States:
- IDLE: cs=1, wr=1.
- SETUP: 1 cycle; cs=0, wr=1, rs/data driven.
- WR_LO: WR_LOW_CYC cycles; wr=0.
- WR_HI: WR_HIGH_CYC cycles; wr=1.
- CS_GAP: 1 cycle; cs=1.
REQ-007 In IDLE with at least one valid, ready SHALL assert combinationally to exactly one winner; the word latches and the FSM enters SETUP next cycle.
REQ-008 Latency for an accept at cycle T:
- SETUP at T+1; WR_LO at T+2..T+1+WR_LOW_CYC; then WR_HI.
- With defaults, a single word occupies T+1..T+6 and the next accept is possible at T+7.
REQ-009 On the last WR_HI cycle, if the owner's lock was high at its last accept, it is valid now, and the burst count < MAX_BURST, its ready SHALL assert and the FSM goes to SETUP; otherwise the FSM goes to CS_GAP, then IDLE.
REQ-010 The locked word period SHALL be 1+WR_LOW_CYC+WR_HIGH_CYC cycles (5 with defaults), with cs held low throughout.
REQ-011 A locked owner that drops valid at the continuation point SHALL lose the grant (CS_GAP); the grant is not held waiting.
REQ-012 The burst counter SHALL reset to 1 on each IDLE grant and increment on each continuation; at MAX_BURST it forces release even if lock is high.
REQ-013 lcd_rs and data_output SHALL be registered, stable from SETUP through the last WR_HI cycle, and change only at SETUP entry.
REQ-014 lcd_rd SHALL be constantly 1; the bus is write-only.
REQ-015 The non-owner's ready SHALL be 0 whenever busy is 1.
REQ-016 Phase counters SHALL be 4 bits; the burst counter SHALL be 8 bits; no counter may wrap.

Reset
REQ-017 On any clock edge with n_rst=0, including mid-transfer, outputs SHALL be driven next cycle to:
- state IDLE, lcd_cs=1, lcd_wr=1, lcd_rd=1, lcd_rs=0;
- data_output=0, grant=00, busy=0;
- both ready=0, burst counter=0, last-owner=port 1.
REQ-018 A word interrupted by reset SHALL be dropped, not replayed.

Configuration
REQ-019 With LCD_ARB_ROUND_ROBIN_EN defined, simultaneous valids in IDLE SHALL grant the port not granted last.
REQ-020 Without LCD_ARB_ROUND_ROBIN_EN, port 0 SHALL always win ties, and the last-owner register SHALL be absent.

Structure
REQ-021 Package lcd_bus_pkg SHALL hold:
- the state enum;
- bus idle constants (CS/WR/RD idle = 1);
- the 16-bit data-width constant.
REQ-022 Winner selection SHALL be sub-module lcd_rr_arbiter: 2 valids plus last-owner in, one-hot winner out, combinational.

Verification
REQ-023 req0 only, rs=0, data=16'h0022, lock=0, defaults -> ready0 at T; cs low T+1..T+5; wr low T+2..T+3; data_output=16'h0022; idle-accept possible at T+7.
REQ-024 req1 locked burst of 3 words 16'hF800, 16'h07E0, 16'h001F -> cs low for 15 continuous cycles; 3 wr low pulses spaced 5 cycles; grant=10 throughout.
REQ-025 Both valid in IDLE, round robin on, last owner = port 0 -> port 1 granted; repeat -> port 0 granted; macro off -> port 0 both times.
REQ-026 MAX_BURST=4, req0 lock held with 6 words queued, req1 valid -> release after word 4 (CS_GAP); req1 granted next (round robin on).
REQ-027 n_rst low during WR_LO -> next cycle: cs=1, wr=1, data_output=0, grant=00, busy=0; re-request -> normal SETUP with no stale word.
